// File: rtl/valve_cond_gen.sv
// Periodic condition-stream generator for a downstream valve.
// It repeats ON_LEN ones and then OFF_LEN zeros. A new pattern is accepted only while idle or at a period boundary.
module valve_cond_gen #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               cfg_ready,
    input  logic               cfg_valid,
    input  logic [2*CNT_W-1:0] cfg_data,
    input  logic               dout_ready,
    output logic               dout_valid,
    output logic               dout_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   on_len, on_len_n;
    logic [CNT_W-1:0]   off_len, off_len_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   cur_len;
    logic [CNT_W-1:0]   cfg_on;
    logic [CNT_W-1:0]   cfg_off;
    logic               hs;
    logic               last;
    logic               pend;
    logic               cfg_acc;

    assign cfg_on  = cfg_data[CNT_W-1:0];
    assign cfg_off = cfg_data[2*CNT_W-1:CNT_W];

    assign dout_valid = (state != IDLE);
    assign dout_data  = (state == ON);

    // cur_len is never zero in ON or OFF, so cur_len-1 cannot wrap while it is used
    assign cur_len = (state == ON) ? on_len : off_len;
    assign hs      = dout_valid & dout_ready;
    assign last    = hs & (cnt == cur_len - CNT_W'(1));
    assign pend    = last & ((state == OFF) | ((state == ON) & (off_len == '0)));

    assign cfg_ready = (state == IDLE) | pend;
    assign cfg_acc   = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            on_len  <= '0;
            off_len <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_n;
            on_len  <= on_len_n;
            off_len <= off_len_n;
            cnt     <= cnt_n;
        end
    end

    // An accepted cfg takes priority over the repeat transition at a period end
    always_comb begin
        state_n   = state;
        on_len_n  = on_len;
        off_len_n = off_len;
        cnt_n     = cnt;
        if (cfg_acc) begin
            on_len_n  = cfg_on;
            off_len_n = cfg_off;
            cnt_n     = '0;
            if (cfg_on != '0) begin
                state_n = ON;
            end else if (cfg_off != '0) begin
                state_n = OFF;
            end else begin
                state_n = IDLE;
            end
        end else if (last) begin
            cnt_n = '0;
            case (state)
                ON:      if (off_len != '0) state_n = OFF;
                OFF:     if (on_len != '0)  state_n = ON;
                default: state_n = state;
            endcase
        end else if (hs) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_valve_cond_gen.sv
// Directed self-checking bench for valve_cond_gen.
// Each scenario task drives its stimulus and checks against hand-computed expected values.
module tb_valve_cond_gen;

    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic               cfg_ready;
    logic               cfg_valid;
    logic [2*CNT_W-1:0] cfg_data;
    logic               dout_ready;
    logic               dout_valid;
    logic               dout_data;

    int checks = 0;
    int errors = 0;

    valve_cond_gen #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_ready  (cfg_ready),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout_data  (dout_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1-2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        dout_ready = 1'b0;
        rst        = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic load_cfg(input logic [CNT_W-1:0] on_l, input logic [CNT_W-1:0] off_l);
        cfg_valid = 1'b1;
        cfg_data  = {off_l, on_l};
        tick();
        cfg_valid = 1'b0;
        cfg_data  = '0;
    endtask

    task automatic test_reset();
        do_reset();
        dout_ready = 1'b1;
        load_cfg(8'd1, 8'd0);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_valid got %b want 0", dout_valid);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_async_cfg_ready got %b want 1", cfg_ready);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle_valid cycle %0d got %b want 0", i, dout_valid);
            end
        end
    endtask

    task automatic test_basic();
        logic exp_tok [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        dout_ready = 1'b1;
        cfg_valid  = 1'b1;
        cfg_data   = {8'd1, 8'd2};
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle got ready=%b valid=%b want ready=1 valid=0", cfg_ready, dout_valid);
        end
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== exp_tok[i]) begin
                errors++;
                $display("[TB] FAIL basic_token %0d got valid=%b data=%b want valid=1 data=%b",
                         i, dout_valid, dout_data, exp_tok[i]);
            end
            checks++;
            if (cfg_ready !== !exp_tok[i]) begin
                errors++;
                $display("[TB] FAIL basic_cfg_ready %0d got %b want %b", i, cfg_ready, !exp_tok[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int   acc;
        int   cyc;
        logic stalled;
        logic held;
        logic exp_d;
        do_reset();
        load_cfg(8'd2, 8'd1);
        acc     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = 1'b0;
        void'($urandom(32'd1234));
        while (acc < 12 && cyc < 300) begin
            dout_ready = 1'($urandom_range(0, 1));
            #1;
            if (stalled) begin
                checks++;
                if (dout_data !== held || dout_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL stall_hold cycle %0d got valid=%b data=%b want valid=1 data=%b",
                             cyc, dout_valid, dout_data, held);
                end
            end
            exp_d = (acc % 3) != 2;
            checks++;
            if (cfg_ready !== (dout_ready && !exp_d)) begin
                errors++;
                $display("[TB] FAIL stall_cfg_ready cycle %0d got %b want %b", cyc, cfg_ready, dout_ready && !exp_d);
            end
            if (dout_ready) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_data !== exp_d) begin
                    errors++;
                    $display("[TB] FAIL stall_token %0d got valid=%b data=%b want valid=1 data=%b",
                             acc, dout_valid, dout_data, exp_d);
                end
                acc++;
            end
            stalled = !dout_ready;
            held    = exp_d;
            cyc++;
            tick();
        end
        checks++;
        if (acc < 12) begin
            errors++;
            $display("[TB] FAIL stall_timeout got %0d tokens want 12", acc);
        end
        dout_ready = 1'b1;
    endtask

    task automatic test_degenerate();
        int ones;
        int zeros;
        int pends;
        int pend_idx;
        logic tok510;
        do_reset();
        dout_ready = 1'b1;
        load_cfg(8'd0, 8'd3);
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== 1'b0 || cfg_ready !== (i % 3 == 2)) begin
                errors++;
                $display("[TB] FAIL off_only %0d got valid=%b data=%b ready=%b want 1 0 %b",
                         i, dout_valid, dout_data, cfg_ready, (i % 3 == 2));
            end
            tick();
        end
        do_reset();
        dout_ready = 1'b1;
        load_cfg(8'd3, 8'd0);
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== 1'b1 || cfg_ready !== (i % 3 == 2)) begin
                errors++;
                $display("[TB] FAIL on_only %0d got valid=%b data=%b ready=%b want 1 1 %b",
                         i, dout_valid, dout_data, cfg_ready, (i % 3 == 2));
            end
            tick();
        end
        do_reset();
        dout_ready = 1'b1;
        load_cfg(8'd255, 8'd255);
        ones     = 0;
        zeros    = 0;
        pends    = 0;
        pend_idx = -1;
        tok510   = 1'b0;
        for (int i = 0; i < 511; i++) begin
            #1;
            if (i < 255) begin
                if (dout_valid === 1'b1 && dout_data === 1'b1) ones++;
            end else if (i < 510) begin
                if (dout_valid === 1'b1 && dout_data === 1'b0) zeros++;
            end else begin
                tok510 = dout_data;
            end
            if (i < 510 && cfg_ready === 1'b1) begin
                pends++;
                pend_idx = i;
            end
            tick();
        end
        checks++;
        if (ones !== 255) begin
            errors++;
            $display("[TB] FAIL max_ones got %0d want 255", ones);
        end
        checks++;
        if (zeros !== 255) begin
            errors++;
            $display("[TB] FAIL max_zeros got %0d want 255", zeros);
        end
        checks++;
        if (tok510 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_repeat got %b want 1", tok510);
        end
        checks++;
        if (pends !== 1 || pend_idx !== 509) begin
            errors++;
            $display("[TB] FAIL max_pend got count=%0d idx=%0d want count=1 idx=509", pends, pend_idx);
        end
    endtask

    task automatic test_reconfig();
        logic exp_a [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic exp_b [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic exp_c [2] = '{1'b1, 1'b0};
        do_reset();
        dout_ready = 1'b1;
        load_cfg(8'd2, 8'd2);
        cfg_valid = 1'b1;
        cfg_data  = {8'd1, 8'd1};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dout_data !== exp_a[i] || cfg_ready !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL reconf_hold %0d got data=%b ready=%b want data=%b ready=%b",
                         i, dout_data, cfg_ready, exp_a[i], (i == 3));
            end
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = '0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== exp_b[i]) begin
                errors++;
                $display("[TB] FAIL reconf_new %0d got valid=%b data=%b want valid=1 data=%b",
                         i, dout_valid, dout_data, exp_b[i]);
            end
            tick();
        end
        cfg_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (dout_data !== exp_c[i] || cfg_ready !== (i == 1)) begin
                errors++;
                $display("[TB] FAIL reconf_stop %0d got data=%b ready=%b want data=%b ready=%b",
                         i, dout_data, cfg_ready, exp_c[i], (i == 1));
            end
            tick();
        end
        cfg_valid = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reconf_idle got valid=%b ready=%b want valid=0 ready=1", dout_valid, cfg_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dout_ready = 1'b1;
        load_cfg(8'd2, 8'd3);
        tick();
        tick();
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_off_phase got valid=%b data=%b want valid=1 data=0", dout_valid, dout_data);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset got valid=%b ready=%b want valid=0 ready=1", dout_valid, cfg_ready);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_after_release got valid=%b want 0", dout_valid);
        end
        load_cfg(8'd1, 8'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== 1'b1 || cfg_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL const_one %0d got valid=%b data=%b ready=%b want 1 1 1",
                         i, dout_valid, dout_data, cfg_ready);
            end
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_data   = '0;
        dout_ready = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_stall();
        test_degenerate();
        test_reconfig();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
